// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 writeback path: source-select codes,
// writeback FSM states and the buffered entry layout.
package msrv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] WB_ALU     = 3'd0;
  localparam logic [SEL_W-1:0] WB_LU      = 3'd1;
  localparam logic [SEL_W-1:0] WB_IMM     = 3'd2;
  localparam logic [SEL_W-1:0] WB_IADDER  = 3'd3;
  localparam logic [SEL_W-1:0] WB_CSR     = 3'd4;
  localparam logic [SEL_W-1:0] WB_PC_PLUS = 3'd5;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LU = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Codes above WB_PC_PLUS carry no source; such entries must never write.
  function automatic logic sel_is_defined(input logic [SEL_W-1:0] sel);
    return sel <= WB_PC_PLUS;
  endfunction

endpackage

// File: rtl/msrv32_skid_buf.sv
// Two-entry valid/ready FIFO. Ready is derived only from registered occupancy,
// so a pop while full raises push_ready_out one cycle later.
module msrv32_skid_buf #(
  parameter int WIDTH = 38
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             push_valid_in,
  input  logic [WIDTH-1:0] push_data_in,
  output logic             push_ready_out,
  output logic             pop_valid_out,
  input  logic             pop_ready_in,
  output logic [WIDTH-1:0] pop_data_out,
  output logic [1:0]       count_out
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  assign push_ready_out = (r_count != 2'd2);
  assign pop_valid_out  = (r_count != 2'd0);
  assign pop_data_out   = pop_valid_out ? r_mem[r_rd_ptr] : '0;
  assign count_out      = r_count;
  assign w_push         = push_valid_in & push_ready_out;
  assign w_pop          = pop_valid_out & pop_ready_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush_in) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_wb_pipe_unit.sv
// Writeback stage: selects the result source, waits for load data when needed
// and queues {rd, wr_en, data} toward the register file through a skid buffer.
module msrv32_wb_pipe_unit
  import msrv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              in_valid_in,
  output logic              in_ready_out,
  input  logic [SEL_W-1:0]  wb_mux_sel_reg_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic              rd_wr_en_in,
  input  logic              alu_src_reg_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   imm_reg_in,
  input  logic [XLEN-1:0]   iadder_out_reg_in,
  input  logic [XLEN-1:0]   csr_data_in,
  input  logic [XLEN-1:0]   pc_plus_4_reg_in,
  input  logic [XLEN-1:0]   lu_output_in,
  input  logic              lu_valid_in,
  output logic [XLEN-1:0]   alu_2nd_src_mux_out,
  output logic              wb_valid_out,
  input  logic              wb_ready_in,
  output logic [REG_AW-1:0] wb_rd_addr_out,
  output logic              wb_wr_en_out,
  output logic [XLEN-1:0]   wb_data_out,
  output wb_state_t         dbg_state_out,
  output logic [1:0]        dbg_occupancy_out
);

  localparam int EW = REG_AW + 1 + XLEN;

  wb_state_t         r_state;
  wb_state_t         w_state_next;
  logic [REG_AW-1:0] r_rd;
  logic              r_wr_en;
  logic [XLEN-1:0]   w_src_data;
  logic              w_wr_en_now;
  logic              w_accept;
  logic              w_push;
  logic [EW-1:0]     w_push_data;
  logic              w_skid_ready;
  logic [EW-1:0]     w_head;

  assign alu_2nd_src_mux_out = alu_src_reg_in ? rs2_in : imm_reg_in;

  always_comb begin
    w_src_data = '0;
    case (wb_mux_sel_reg_in)
      WB_ALU:     w_src_data = alu_result_in;
      WB_LU:      w_src_data = lu_output_in;
      WB_IMM:     w_src_data = imm_reg_in;
      WB_IADDER:  w_src_data = iadder_out_reg_in;
      WB_CSR:     w_src_data = csr_data_in;
      WB_PC_PLUS: w_src_data = pc_plus_4_reg_in;
      default:    w_src_data = '0;
    endcase
  end

  assign w_wr_en_now  = rd_wr_en_in & (rd_addr_in != '0) & sel_is_defined(wb_mux_sel_reg_in);
  assign in_ready_out = w_skid_ready & (r_state == IDLE);
  assign w_accept     = in_valid_in & in_ready_out & ~flush_in;

  // A load only enters WAIT_LU with a free slot, and nothing else pushes
  // until it completes, so the WAIT_LU push never needs to check ready.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_data  = {rd_addr_in, w_wr_en_now, w_src_data};
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (wb_mux_sel_reg_in == WB_LU && !lu_valid_in) w_state_next = WAIT_LU;
          else                                             w_push       = 1'b1;
        end
      end
      WAIT_LU: begin
        w_push_data = {r_rd, r_wr_en, lu_output_in};
        if (lu_valid_in) begin
          w_push       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush_in) w_state_next = IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_rd    <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_state_next == WAIT_LU) begin
        r_rd    <= rd_addr_in;
        r_wr_en <= w_wr_en_now;
      end
    end
  end

  msrv32_skid_buf #(.WIDTH(EW)) u_skid (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .push_valid_in  (w_push),
    .push_data_in   (w_push_data),
    .push_ready_out (w_skid_ready),
    .pop_valid_out  (wb_valid_out),
    .pop_ready_in   (wb_ready_in),
    .pop_data_out   (w_head),
    .count_out      (dbg_occupancy_out)
  );

  assign wb_rd_addr_out = w_head[EW-1 -: REG_AW];
  assign wb_wr_en_out   = w_head[XLEN];
  assign wb_data_out    = w_head[XLEN-1:0];
  assign dbg_state_out  = r_state;

endmodule

// File: tb/tb_msrv32_wb_pipe_unit.sv
// Directed bench for the writeback stage: a vector table for source selection
// plus hand sequences for load wait, back-pressure, flush and reset.
module tb_msrv32_wb_pipe_unit;
  import msrv32_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [2:0]  wb_mux_sel_reg_in;
  logic [4:0]  rd_addr_in;
  logic        rd_wr_en_in;
  logic        alu_src_reg_in;
  logic [31:0] rs2_in, alu_result_in, imm_reg_in, iadder_out_reg_in;
  logic [31:0] csr_data_in, pc_plus_4_reg_in, lu_output_in;
  logic        lu_valid_in;
  logic [31:0] alu_2nd_src_mux_out;
  logic        wb_valid_out;
  logic        wb_ready_in;
  logic [4:0]  wb_rd_addr_out;
  logic        wb_wr_en_out;
  logic [31:0] wb_data_out;
  wb_state_t   dbg_state_out;
  logic [1:0]  dbg_occupancy_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;
  vec_t vecs[8];

  always #5 clk_in = ~clk_in;

  msrv32_wb_pipe_unit dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .flush_in            (flush_in),
    .in_valid_in         (in_valid_in),
    .in_ready_out        (in_ready_out),
    .wb_mux_sel_reg_in   (wb_mux_sel_reg_in),
    .rd_addr_in          (rd_addr_in),
    .rd_wr_en_in         (rd_wr_en_in),
    .alu_src_reg_in      (alu_src_reg_in),
    .rs2_in              (rs2_in),
    .alu_result_in       (alu_result_in),
    .imm_reg_in          (imm_reg_in),
    .iadder_out_reg_in   (iadder_out_reg_in),
    .csr_data_in         (csr_data_in),
    .pc_plus_4_reg_in    (pc_plus_4_reg_in),
    .lu_output_in        (lu_output_in),
    .lu_valid_in         (lu_valid_in),
    .alu_2nd_src_mux_out (alu_2nd_src_mux_out),
    .wb_valid_out        (wb_valid_out),
    .wb_ready_in         (wb_ready_in),
    .wb_rd_addr_out      (wb_rd_addr_out),
    .wb_wr_en_out        (wb_wr_en_out),
    .wb_data_out         (wb_data_out),
    .dbg_state_out       (dbg_state_out),
    .dbg_occupancy_out   (dbg_occupancy_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [4:0] rd, input logic we);
    in_valid_in       = 1'b1;
    wb_mux_sel_reg_in = sel;
    rd_addr_in        = rd;
    rd_wr_en_in       = we;
  endtask

  task automatic check_head(input string tag, input logic [31:0] data, input logic [4:0] rd,
                            input logic we);
    check({tag, ".valid"}, 32'(wb_valid_out), 32'd1);
    check({tag, ".data"},  wb_data_out, data);
    check({tag, ".rd"},    32'(wb_rd_addr_out), 32'(rd));
    check({tag, ".wr_en"}, 32'(wb_wr_en_out), 32'(we));
  endtask

  task automatic set_sources();
    alu_result_in     = 32'hAAAA_AAAA;
    lu_output_in      = 32'h1234_5678;
    imm_reg_in        = 32'h3333_3333;
    iadder_out_reg_in = 32'hF0F0_F0F0;
    csr_data_in       = 32'hC5C5_C5C5;
    pc_plus_4_reg_in  = 32'h0000_1004;
  endtask

  initial begin
    vecs[0] = '{WB_ALU,     5'd5,  1'b1, 32'hAAAA_AAAA, 1'b1};
    vecs[1] = '{WB_LU,      5'd7,  1'b1, 32'h1234_5678, 1'b1};
    vecs[2] = '{WB_IMM,     5'd1,  1'b1, 32'h3333_3333, 1'b1};
    vecs[3] = '{WB_IADDER,  5'd0,  1'b1, 32'hF0F0_F0F0, 1'b0};
    vecs[4] = '{WB_CSR,     5'd31, 1'b0, 32'hC5C5_C5C5, 1'b0};
    vecs[5] = '{WB_PC_PLUS, 5'd10, 1'b1, 32'h0000_1004, 1'b1};
    vecs[6] = '{3'd6,       5'd3,  1'b1, 32'h0000_0000, 1'b0};
    vecs[7] = '{3'd7,       5'd4,  1'b1, 32'h0000_0000, 1'b0};

    rst_in = 1'b0; flush_in = 1'b0; in_valid_in = 1'b0; wb_mux_sel_reg_in = 3'd0;
    rd_addr_in = 5'd0; rd_wr_en_in = 1'b0; alu_src_reg_in = 1'b0; rs2_in = 32'd0;
    lu_valid_in = 1'b0; wb_ready_in = 1'b1;
    set_sources();
    step(); step();
    rst_in = 1'b1;
    check("rst.valid", 32'(wb_valid_out), 32'd0);
    check("rst.data", wb_data_out, 32'd0);
    check("rst.rd", 32'(wb_rd_addr_out), 32'd0);
    check("rst.wr_en", 32'(wb_wr_en_out), 32'd0);
    check("rst.in_ready", 32'(in_ready_out), 32'd1);
    check("rst.occ", 32'(dbg_occupancy_out), 32'd0);

    // ALU 2nd-source mux
    alu_src_reg_in = 1'b1; rs2_in = 32'h0F0F_0F0F; #1;
    check("mux.rs2", alu_2nd_src_mux_out, 32'h0F0F_0F0F);
    alu_src_reg_in = 1'b0; #1;
    check("mux.imm", alu_2nd_src_mux_out, 32'h3333_3333);

    // Source table, one instruction at a time with the register file ready
    lu_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].sel, vecs[i].rd, vecs[i].we);
      step();
      in_valid_in = 1'b0;
      check_head($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].rd, vecs[i].exp_we);
      step();
      check($sformatf("vec%0d.drained", i), 32'(wb_valid_out), 32'd0);
    end
    lu_valid_in = 1'b0;

    // Load waits three cycles for load-unit data
    lu_output_in = 32'h0;
    drive(WB_LU, 5'd9, 1'b1);
    step();
    in_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lu.wait%0d.in_ready", i), 32'(in_ready_out), 32'd0);
      check($sformatf("lu.wait%0d.valid", i), 32'(wb_valid_out), 32'd0);
      if (i < 2) step();
    end
    check("lu.state", 32'(dbg_state_out), 32'(WAIT_LU));
    lu_valid_in = 1'b1; lu_output_in = 32'h1234_5678;
    step();
    lu_valid_in = 1'b0;
    check_head("lu.done", 32'h1234_5678, 5'd9, 1'b1);
    check("lu.in_ready", 32'(in_ready_out), 32'd1);
    step();

    // Back-pressure: three back-to-back pushes into a two-entry buffer
    wb_ready_in = 1'b0;
    imm_reg_in = 32'd1; csr_data_in = 32'd2; pc_plus_4_reg_in = 32'd3;
    drive(WB_IMM, 5'd1, 1'b1);
    step();
    check("bp.in_ready1", 32'(in_ready_out), 32'd1);
    drive(WB_CSR, 5'd2, 1'b1);
    step();
    check("bp.in_ready2", 32'(in_ready_out), 32'd0);
    check("bp.occ2", 32'(dbg_occupancy_out), 32'd2);
    drive(WB_PC_PLUS, 5'd3, 1'b1);
    step();
    check_head("bp.stable", 32'd1, 5'd1, 1'b1);
    check("bp.in_ready3", 32'(in_ready_out), 32'd0);
    wb_ready_in = 1'b1;
    step();
    check_head("bp.pop1", 32'd2, 5'd2, 1'b1);
    check("bp.in_ready4", 32'(in_ready_out), 32'd1);
    step();
    in_valid_in = 1'b0;
    check_head("bp.third", 32'd3, 5'd3, 1'b1);
    check("bp.occ_pushpop", 32'(dbg_occupancy_out), 32'd1);
    step();
    check("bp.empty", 32'(wb_valid_out), 32'd0);
    set_sources();

    // Flush with two buffered entries and a simultaneous offer
    wb_ready_in = 1'b0;
    drive(WB_ALU, 5'd5, 1'b1); step();
    drive(WB_IMM, 5'd6, 1'b1); step();
    check("fl.occ_before", 32'(dbg_occupancy_out), 32'd2);
    in_ready_out_wait();
    flush_in = 1'b1; drive(WB_ALU, 5'd7, 1'b1);
    step();
    flush_in = 1'b0; in_valid_in = 1'b0;
    check("fl.valid", 32'(wb_valid_out), 32'd0);
    check("fl.occ", 32'(dbg_occupancy_out), 32'd0);
    step();
    check("fl.nothing_accepted", 32'(wb_valid_out), 32'd0);
    wb_ready_in = 1'b1;

    // Reset while waiting for load data
    drive(WB_LU, 5'd8, 1'b1);
    step();
    in_valid_in = 1'b0;
    check("rw.state_wait", 32'(dbg_state_out), 32'(WAIT_LU));
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    check("rw.state", 32'(dbg_state_out), 32'(IDLE));
    check("rw.occ", 32'(dbg_occupancy_out), 32'd0);
    check("rw.valid", 32'(wb_valid_out), 32'd0);
    check("rw.in_ready", 32'(in_ready_out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hold one extra cycle with the buffer full so flush is applied to a settled state.
  task automatic in_ready_out_wait();
    in_valid_in = 1'b0;
    step();
    check("fl.full_not_ready", 32'(in_ready_out), 32'd0);
  endtask

endmodule
